// File: rtl/detector_param.sv
// ---------------------------------------------------------------------------
// detector_param
// Serial pattern detector. Bits on `e` are accepted on edges where e_valido=1
// and shifted into an N-bit history (newest bit at the LSB). Once N bits have
// been seen since the last clear, a history equal to the pattern register
// produces a one-cycle registered pulse on `s`.
//
// Parameters
//   N          pattern length (2..16)
//   PADRAO_RST pattern loaded at reset (MSB = first bit of the sequence)
//   SOBREPOR   1 = overlapping detection, 0 = non-overlapping
//   LARG_CONT  match counter width
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   e_valido   accept strobe for e
//   e          serial data bit
//   carregar   load strobe: padrao_in -> pattern, clears fill (beats e_valido)
//   padrao_in  new pattern
//   s          match pulse, one cycle after the completing bit
//   contagem   saturating match count
//
// Optional feature: define DETECTOR_CONTADOR_EN to build the match counter.
// Without it contagem is tied to 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module detector_param #(
    parameter int             N          = 4,
    parameter logic [N-1:0]   PADRAO_RST = 4'b1011,
    parameter int             SOBREPOR   = 1,
    parameter int             LARG_CONT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 e_valido,
    input  logic                 e,
    input  logic                 carregar,
    input  logic [N-1:0]         padrao_in,
    output logic                 s,
    output logic [LARG_CONT-1:0] contagem
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [N-1:0]  padrao;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic          aceita;
    logic [N-1:0]  hist_nxt;
    logic [FW-1:0] fill_nxt;
    logic          match;

    // A load on the same edge discards the incoming bit.
    assign aceita   = e_valido && !carregar;
    assign hist_nxt = {hist[N-2:0], e};
    assign fill_nxt = (fill == FILL_MAX) ? FILL_MAX : fill + FW'(1);
    assign match    = aceita && (hist_nxt == padrao) && (fill_nxt == FILL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            padrao <= PADRAO_RST;
            hist   <= '0;
            fill   <= '0;
            s      <= 1'b0;
        end else if (carregar) begin
            // History is left alone: fill must climb back to N before a
            // match, by which point every history bit is new.
            padrao <= padrao_in;
            fill   <= '0;
            s      <= 1'b0;
        end else if (aceita) begin
            hist <= hist_nxt;
            // Non-overlapping mode restarts the fill so no bit serves twice.
            fill <= (match && SOBREPOR == 0) ? '0 : fill_nxt;
            s    <= match;
        end else begin
            s <= 1'b0;
        end
    end

`ifdef DETECTOR_CONTADOR_EN
    localparam logic [LARG_CONT-1:0] CONT_MAX = '1;

    logic [LARG_CONT-1:0] cont;

    // match is already gated by !carregar, so a load leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst)
            cont <= '0;
        else if (match && cont != CONT_MAX)
            cont <= cont + LARG_CONT'(1);
    end

    assign contagem = cont;
`else
    assign contagem = '0;
`endif

endmodule

// File: tb/tb_detector_param.sv
module tb_detector_param;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, e_valido, e, carregar;
    logic [N-1:0] padrao_in;
    logic s_o, s_n;
    logic [7:0] cnt_o;
    logic [1:0] cnt_n;

    always #5 clk = ~clk;

    // Overlapping instance with an 8-bit counter.
    detector_param #(.N(N), .SOBREPOR(1), .LARG_CONT(8)) u_ovl (
        .clk(clk), .rst(rst), .e_valido(e_valido), .e(e), .carregar(carregar),
        .padrao_in(padrao_in), .s(s_o), .contagem(cnt_o)
    );

    // Non-overlapping instance with a 2-bit counter (saturates quickly).
    detector_param #(.N(N), .SOBREPOR(0), .LARG_CONT(2)) u_nov (
        .clk(clk), .rst(rst), .e_valido(e_valido), .e(e), .carregar(carregar),
        .padrao_in(padrao_in), .s(s_n), .contagem(cnt_n)
    );

    typedef struct {
        logic       s_o;
        logic       s_n;
        logic [7:0] c_o;
        logic [1:0] c_n;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int pulses_o = 0;
    int pulses_n = 0;

    // Reference model: bits accepted since the last clear, as a plain list.
    int           bits_o[$];
    int           bits_n[$];
    logic [N-1:0] m_pat;
    int           m_cnt_o, m_cnt_n;

`ifdef DETECTOR_CONTADOR_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit tail_is_pat(input int q[$], input logic [N-1:0] pat);
        if (q.size() < N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (q[q.size() - N + i] != int'(pat[N-1-i])) return 1'b0;
        return 1'b1;
    endfunction

    // Apply one cycle of stimulus and push the response expected after the edge.
    task automatic step(input bit r, input bit v, input bit b, input bit ld,
                        input logic [N-1:0] pin);
        exp_t x;
        bit   mo, mn;
        @(negedge clk);
        rst = r; e_valido = v; e = b; carregar = ld; padrao_in = pin;
        mo = 1'b0; mn = 1'b0;
        if (r) begin
            m_pat = 4'b1011;
            bits_o.delete(); bits_n.delete();
            m_cnt_o = 0; m_cnt_n = 0;
        end else if (ld) begin
            m_pat = pin;
            bits_o.delete(); bits_n.delete();
        end else if (v) begin
            bits_o.push_back(int'(b));
            bits_n.push_back(int'(b));
            if (bits_o.size() > N) void'(bits_o.pop_front());
            mo = tail_is_pat(bits_o, m_pat);
            mn = tail_is_pat(bits_n, m_pat);
            if (mn) bits_n.delete();
            if (mo && m_cnt_o < 255) m_cnt_o++;
            if (mn && m_cnt_n < 3)   m_cnt_n++;
        end
        x.s_o = mo;
        x.s_n = mn;
        x.c_o = CNT_EN ? 8'(m_cnt_o) : 8'd0;
        x.c_n = CNT_EN ? 2'(m_cnt_n) : 2'd0;
        exp_q.push_back(x);
    endtask

    task automatic bits(input string str);
        for (int i = 0; i < str.len(); i++)
            step(0, 1, str[i] == "1", 0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: one response per clock edge once stimulus has started.
    always @(posedge clk) begin
        exp_t x;
        #2;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("s_ovl", int'(s_o), int'(x.s_o));
            chk("s_nov", int'(s_n), int'(x.s_n));
            chk("cnt_ovl", int'(cnt_o), int'(x.c_o));
            chk("cnt_nov", int'(cnt_n), int'(x.c_n));
            if (s_o === 1'b1) pulses_o++;
            if (s_n === 1'b1) pulses_n++;
        end
    end

    initial begin
        int p0, p1;
        rst = 1'b1; e_valido = 1'b0; e = 1'b0; carregar = 1'b0; padrao_in = '0;

        // Reset state, then 1011011 on the default pattern.
        step(1, 0, 0, 0, '0);
        drain();
        chk("reset_s", int'(s_o), 0);
        chk("reset_cnt", int'(cnt_o), 0);
        p0 = pulses_o;
        bits("1011011");
        drain();
        chk("seq1011011_pulses", pulses_o - p0, 2);
        chk("seq1011011_cnt", int'(cnt_o), CNT_EN ? 2 : 0);

        // Pattern 1111, eight ones: 5 overlapping vs 2 non-overlapping.
        step(0, 0, 0, 1, 4'b1111);
        p0 = pulses_o; p1 = pulses_n;
        bits("11111111");
        drain();
        chk("ones_ovl_pulses", pulses_o - p0, 5);
        chk("ones_nov_pulses", pulses_n - p1, 2);

        // Gap in e_valido does not break a sequence.
        step(1, 0, 0, 0, '0);
        p0 = pulses_o;
        bits("101");
        repeat (3) step(0, 0, 1, 0, '0);
        bits("1");
        drain();
        chk("gap_pulses", pulses_o - p0, 1);

        // Load beats e_valido: the bit is dropped.
        step(1, 0, 0, 0, '0);
        p0 = pulses_o;
        bits("101");
        step(0, 1, 1, 1, 4'b0110);
        bits("0110");
        drain();
        chk("load_pulses", pulses_o - p0, 1);

        // Reset mid-sequence discards the partial match.
        step(1, 0, 0, 0, '0);
        bits("101");
        step(1, 1, 1, 0, '0);
        p0 = pulses_o;
        bits("1");
        drain();
        chk("rst_mid_pulses", pulses_o - p0, 0);
        chk("rst_mid_cnt", int'(cnt_o), 0);

        // Saturation of the 2-bit counter: 5 non-overlapping matches of 1011.
        for (int k = 0; k < 5; k++) bits("1011");
        drain();
        chk("sat_cnt_nov", int'(cnt_n), CNT_EN ? 3 : 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, v, b, ld;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            step(r, v, b, ld, N'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detector_param.md
DETECTOR_PARAM -- requirements
Module: detector_param

Interface
REQ-001 SHALL have parameter N, default 4, giving the pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter PADRAO_RST, default 4'b1011 (N bits), giving the pattern loaded at reset.
REQ-003 SHALL have parameter SOBREPOR, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter LARG_CONT, default 8, giving the match counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port e_valido, input, 1 bit: e is accepted on an edge where this is 1.
REQ-008 SHALL have port e, input, 1 bit: serial data bit.
REQ-009 SHALL have port carregar, input, 1 bit: load strobe for padrao_in.
REQ-010 SHALL have port padrao_in, input, N bits: new pattern, MSB = first bit of the sequence.
REQ-011 SHALL have port s, output, 1 bit: registered one-cycle match pulse.
REQ-012 SHALL have port contagem, output, LARG_CONT bits: saturating match count.

Function
REQ-013 SHALL hold a pattern register, an N-bit history shift register, and a fill counter (0..N).
REQ-014 SHALL, on an accepted bit, shift e into the history LSB and increment the fill counter, saturating at N.
REQ-015 SHALL declare a match on an accepted bit when the updated history equals the pattern and the updated fill equals N.
REQ-016 SHALL drive s to 1 for exactly the one cycle after the edge that accepted the completing bit, and to 0 otherwise (latency 1).
REQ-017 SHALL keep the history register when SOBREPOR=1 and a match occurs, so that overlapping matches are detected.
REQ-018 SHALL clear the fill counter to 0 on a match when SOBREPOR=0, so that no bit is counted in two matches.
REQ-019 SHALL ignore e and hold all state except s when e_valido=0, with s=0 on the next cycle.
REQ-020 SHALL, when carregar=1, load padrao_in into the pattern register, clear the fill counter, and force s=0 on the next cycle.
REQ-021 SHALL give carregar priority over e_valido when both are 1 on the same edge; the bit is discarded.
REQ-022 SHALL increment contagem by 1 on each match and hold it at 2^LARG_CONT-1 once that value is reached (no wrap).
REQ-023 SHALL leave contagem unchanged when carregar is asserted.

Reset
REQ-024 SHALL, on an edge with rst=1, set the pattern register to PADRAO_RST, history to 0, fill to 0, s to 0 and contagem to 0.
REQ-025 SHALL give rst priority over carregar and e_valido.
REQ-026 SHALL let a reset mid-sequence discard the partial match: N new accepted bits are required before the next match.

Configuration
REQ-027 SHALL compile the match counter only when macro DETECTOR_CONTADOR_EN is defined.
REQ-028 SHALL, without DETECTOR_CONTADOR_EN, keep port contagem but tie it to constant 0 and instantiate no counter flops; s behaviour is unchanged.

Verification
REQ-029 SHALL cover: defaults, SOBREPOR=1, rst pulse then stream 1,0,1,1,0,1,1 with e_valido=1 -> s pulses after bits 4 and 7, contagem=2.
REQ-030 SHALL cover: PADRAO_RST=4'b1111, eight consecutive 1s -> SOBREPOR=1 gives 5 pulses (bits 4-8); SOBREPOR=0 gives 2 pulses (bits 4 and 8).
REQ-031 SHALL cover: stream 1,0,1 then e_valido=0 for 3 cycles then 1 -> single s pulse after the final bit, s=0 during gap cycles.
REQ-032 SHALL cover: carregar=1 with padrao_in=4'b0110 while e_valido=1, e=1 after bits 1,0,1 -> bit discarded, no pulse; then 0,1,1,0 -> one pulse.
REQ-033 SHALL cover: rst=1 after bits 1,0,1 then 1 -> no pulse; contagem=0.
REQ-034 SHALL cover: LARG_CONT=2 with DETECTOR_CONTADOR_EN, 5 matches -> contagem saturates at 3; without the macro, contagem stays 0.
